nv_nvdla_cdma_single_reg_param: RTL and testbench

//  Parametrised CDMA single (non-shadowed) register bank: arbiter weights per DMA channel, ping-pong

---
 rtl/nv_nvdla_cdma_single_reg_param.sv | 204 ++++++++++++++++++++
 tb/tb_nv_nvdla_cdma_single_reg_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cdma_single_reg_param.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_single_reg_param
//
// Parametrised CDMA single (non-shadowed) register bank. Holds the arbiter
// weights per DMA channel, the write-mem-bubble weight, the ping-pong
// producer pointer over NUM_GROUPS register groups, and a sticky W1C
// interrupt status with mask driving a registered interrupt. Reads are
// registered (one cycle latency).
//
// Ports
//   nvdla_core_clk  in   core clock
//   nvdla_core_rst  in   asynchronous reset, active high
//   reg_offset      in   [11:0] register byte offset
//   reg_wr_data     in   [31:0] write data
//   reg_wr_en       in   write strobe, one cycle per write
//   reg_rd_en       in   read strobe, one cycle per read
//   reg_rd_data     out  [31:0] read data, valid with reg_rd_valid
//   reg_rd_valid    out  read-data strobe
//   arb_weight      out  [NUM_CH*WGT_W-1:0] channel k weight at [k*WGT_W +: WGT_W]
//   arb_wmb         out  [WGT_W-1:0] write-mem-bubble weight
//   producer        out  [PTR_W-1:0] group software is programming
//   consumer        in   [PTR_W-1:0] group hardware is executing
//   status          in   [2*NUM_GROUPS-1:0] group g status at [2g +: 2]
//   flush_done      in   CBUF flush complete (level)
//   intr            out  masked interrupt
//
// Register map (unused bits read 0, unknown offsets read 0 / ignore writes)
//   0x000 STATUS       RO  status
//   0x004 POINTER      producer [PTR_W-1:0] RW, consumer [16 +: PTR_W] RO
//   0x008 ARB0         weight ch0 [WGT_W-1:0], wmb [16 +: WGT_W]
//   0x00C FLUSH        RO  flush_done [0]
//   0x010 INTR_STATUS  W1C [0] flush rise, [1] producer write rejected
//   0x014 INTR_MASK    RW  [1:0]
//   0x020+4*(k-1)      ARBk weight, k = 1..NUM_CH-1
// ---------------------------------------------------------------------------
module nv_nvdla_cdma_single_reg_param #(
    parameter int               NUM_GROUPS = 2,
    parameter int               NUM_CH     = 1,
    parameter int               WGT_W      = 4,
    parameter logic [WGT_W-1:0] WGT_RST    = WGT_W'(4'hF),
    parameter logic [WGT_W-1:0] WMB_RST    = WGT_W'(4'h3),
    parameter int               PTR_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
    input  logic [11:0]               reg_offset,
    input  logic [31:0]               reg_wr_data,
    input  logic                      reg_wr_en,
    input  logic                      reg_rd_en,
    output logic [31:0]               reg_rd_data,
    output logic                      reg_rd_valid,
    output logic [NUM_CH*WGT_W-1:0]   arb_weight,
    output logic [WGT_W-1:0]          arb_wmb,
    output logic [PTR_W-1:0]          producer,
    input  logic [PTR_W-1:0]          consumer,
    input  logic [2*NUM_GROUPS-1:0]   status,
    input  logic                      flush_done,
    output logic                      intr
);

    // Byte offset of the extra-channel weight register for channel k (k >= 1).
    function automatic logic [11:0] arb_off(input int k);
        arb_off = 12'(32'h0000_0020 + 32'(4 * (k - 1)));
    endfunction

    logic [NUM_CH*WGT_W-1:0] arb_weight_r;
    logic [WGT_W-1:0]        arb_wmb_r;
    logic [PTR_W-1:0]        producer_r;
    logic [1:0]              intr_status_r;
    logic [1:0]              intr_mask_r;
    logic                    intr_r;
    logic                    flush_done_d_r;
    logic [31:0]             reg_rd_data_r;
    logic                    reg_rd_valid_r;

    logic                    wr_pointer_s;
    logic                    wr_arb0_s;
    logic                    wr_istat_s;
    logic                    wr_imask_s;
    logic                    prod_ok_s;
    logic                    flush_rise_s;
    logic [1:0]              intr_set_s;
    logic [1:0]              intr_clr_s;
    logic [1:0]              intr_status_nxt_s;
    logic [WGT_W-1:0]        arbk_data_s;
    logic [31:0]             rd_mux_s;
    logic                    unused_wr_data_s;

    // Upper write-data bits have no destination in any register.
    assign unused_wr_data_s = &{1'b0, reg_wr_data};

    // Write decode, producer range check and interrupt status next state.
    always_comb begin
        wr_pointer_s = reg_wr_en & (reg_offset == 12'h004);
        wr_arb0_s    = reg_wr_en & (reg_offset == 12'h008);
        wr_istat_s   = reg_wr_en & (reg_offset == 12'h010);
        wr_imask_s   = reg_wr_en & (reg_offset == 12'h014);
        prod_ok_s    = (reg_wr_data[15:0] < 16'(NUM_GROUPS));
        // flush_done_d resets to 1 so a level already high at reset is no edge
        flush_rise_s = flush_done & ~flush_done_d_r;
        intr_set_s   = {wr_pointer_s & ~prod_ok_s, flush_rise_s};
        if (wr_istat_s) begin
            intr_clr_s = reg_wr_data[1:0];
        end else begin
            intr_clr_s = 2'b00;
        end
        // A set event in the same cycle as its clear wins
        intr_status_nxt_s = (intr_status_r & ~intr_clr_s) | intr_set_s;
    end

    // Weight of the addressed extra channel (zero when no channel matches).
    always_comb begin
        arbk_data_s = {WGT_W{1'b0}};
        for (int k = 1; k < NUM_CH; k++) begin
            arbk_data_s = arbk_data_s |
                ({WGT_W{reg_offset == arb_off(k)}} & arb_weight_r[k*WGT_W +: WGT_W]);
        end
    end

    // Read-data selection from pre-write register contents.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (reg_offset)
            12'h000: rd_mux_s[2*NUM_GROUPS-1:0] = status;
            12'h004: begin
                rd_mux_s[PTR_W-1:0]   = producer_r;
                rd_mux_s[16 +: PTR_W] = consumer;
            end
            12'h008: begin
                rd_mux_s[WGT_W-1:0]   = arb_weight_r[WGT_W-1:0];
                rd_mux_s[16 +: WGT_W] = arb_wmb_r;
            end
            12'h00C: rd_mux_s[0]   = flush_done;
            12'h010: rd_mux_s[1:0] = intr_status_r;
            12'h014: rd_mux_s[1:0] = intr_mask_r;
            default: rd_mux_s[WGT_W-1:0] = arbk_data_s;
        endcase
    end

    // Arbiter weights and write-mem-bubble weight.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            arb_weight_r <= {NUM_CH{WGT_RST}};
            arb_wmb_r    <= WMB_RST;
        end else begin
            if (wr_arb0_s) begin
                arb_weight_r[WGT_W-1:0] <= reg_wr_data[WGT_W-1:0];
                arb_wmb_r               <= reg_wr_data[16 +: WGT_W];
            end
            for (int k = 1; k < NUM_CH; k++) begin
                if (reg_wr_en && (reg_offset == arb_off(k))) begin
                    arb_weight_r[k*WGT_W +: WGT_W] <= reg_wr_data[WGT_W-1:0];
                end
            end
        end
    end

    // Producer pointer: out-of-range writes are dropped and flagged.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            producer_r <= {PTR_W{1'b0}};
        end else if (wr_pointer_s && prod_ok_s) begin
            producer_r <= reg_wr_data[PTR_W-1:0];
        end
    end

    // Interrupt status, mask, flush edge history and registered interrupt.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            intr_status_r  <= 2'b00;
            intr_mask_r    <= 2'b00;
            intr_r         <= 1'b0;
            flush_done_d_r <= 1'b1;
        end else begin
            intr_status_r  <= intr_status_nxt_s;
            flush_done_d_r <= flush_done;
            intr_r         <= |(intr_status_r & intr_mask_r);
            if (wr_imask_s) begin
                intr_mask_r <= reg_wr_data[1:0];
            end
        end
    end

    // Registered read path; data holds between reads.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            reg_rd_data_r  <= 32'h0000_0000;
            reg_rd_valid_r <= 1'b0;
        end else begin
            reg_rd_valid_r <= reg_rd_en;
            if (reg_rd_en) begin
                reg_rd_data_r <= rd_mux_s;
            end
        end
    end

    assign reg_rd_data  = reg_rd_data_r;
    assign reg_rd_valid = reg_rd_valid_r;
    assign arb_weight   = arb_weight_r;
    assign arb_wmb      = arb_wmb_r;
    assign producer     = producer_r;
    assign intr         = intr_r;

endmodule

// File: tb/tb_nv_nvdla_cdma_single_reg_param.sv
// Scoreboard bench for nv_nvdla_cdma_single_reg_param with NUM_GROUPS=3, NUM_CH=3.
module tb_nv_nvdla_cdma_single_reg_param;
    localparam int NG  = 3;
    localparam int NCH = 3;
    localparam int W   = 4;
    localparam int PW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [11:0]       off;
    logic [31:0]       wd;
    logic              we;
    logic              re;
    logic [31:0]       rdd;
    logic              rv;
    logic [NCH*W-1:0]  aw;
    logic [W-1:0]      wmb;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     cons;
    logic [2*NG-1:0]   st;
    logic              fd;
    logic              intr;

    always #5 clk = ~clk;

    nv_nvdla_cdma_single_reg_param #(
        .NUM_GROUPS(NG), .NUM_CH(NCH), .WGT_W(W)
    ) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .reg_offset(off), .reg_wr_data(wd), .reg_wr_en(we), .reg_rd_en(re),
        .reg_rd_data(rdd), .reg_rd_valid(rv),
        .arb_weight(aw), .arb_wmb(wmb), .producer(prod), .consumer(cons),
        .status(st), .flush_done(fd), .intr(intr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] expq[$];

    // reference model state
    logic [W-1:0] m_wgt[NCH];
    logic [W-1:0] m_wmb;
    int           m_prod;
    logic [1:0]   m_istat;
    logic [1:0]   m_mask;
    logic         m_fd_d;
    logic         m_intr;
    logic         force_exp = 1'b0;
    logic [31:0]  exp_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_wgt[k] = 4'hF;
        m_wmb   = 4'h3;
        m_prod  = 0;
        m_istat = 2'b00;
        m_mask  = 2'b00;
        m_fd_d  = 1'b1;
        m_intr  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] o);
        logic [31:0] v;
        int idx;
        v = 32'h0;
        case (o)
            12'h000: v = 32'(st);
            12'h004: v = 32'(m_prod) | (32'(cons) << 16);
            12'h008: v = 32'(m_wgt[0]) | (32'(m_wmb) << 16);
            12'h00C: v = 32'(fd);
            12'h010: v = 32'(m_istat);
            12'h014: v = 32'(m_mask);
            default: begin
                if (o >= 12'h020 && o < 12'(32 + 4 * (NCH - 1)) && o[1:0] == 2'b00) begin
                    idx = int'((o - 12'h020) >> 2) + 1;
                    v = 32'(m_wgt[idx]);
                end
            end
        endcase
        return v;
    endfunction

    // Apply this cycle's inputs to the model, clock once, compare outputs.
    task automatic tick();
        logic [1:0] w1c;
        logic [1:0] set;
        logic nxt_intr;
        logic rd_issued;
        rd_issued = re;
        if (re) expq.push_back(force_exp ? exp_val : model_read(off));
        nxt_intr = |(m_istat & m_mask);
        w1c = 2'b00;
        set = 2'b00;
        if (we) begin
            case (off)
                12'h004: if (wd[15:0] < 16'(NG)) m_prod = int'(wd[15:0]); else set[1] = 1'b1;
                12'h008: begin m_wgt[0] = wd[W-1:0]; m_wmb = wd[16 +: W]; end
                12'h010: w1c = wd[1:0];
                12'h014: m_mask = wd[1:0];
                default: for (int k = 1; k < NCH; k++)
                             if (off == 12'(32 + 4 * (k - 1))) m_wgt[k] = wd[W-1:0];
            endcase
        end
        if (fd && !m_fd_d) set[0] = 1'b1;
        m_fd_d  = fd;
        m_istat = (m_istat & ~w1c) | set;
        m_intr  = nxt_intr;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
        chk("rd_valid", 32'(rv), 32'(rd_issued));
        for (int k = 0; k < NCH; k++) chk("arb_weight", 32'(aw[k*W +: W]), 32'(m_wgt[k]));
        chk("arb_wmb", 32'(wmb), 32'(m_wmb));
        chk("producer", 32'(prod), 32'(m_prod));
        chk("intr", 32'(intr), 32'(m_intr));
    endtask

    task automatic wr(input logic [11:0] o, input logic [31:0] d);
        we = 1'b1; off = o; wd = d;
        tick();
    endtask

    task automatic rd_const(input logic [11:0] o, input logic [31:0] e);
        re = 1'b1; off = o; force_exp = 1'b1; exp_val = e;
        tick();
        force_exp = 1'b0;
    endtask

    // Monitor: pop expected read data whenever the DUT presents a read.
    always @(negedge clk) begin
        if (!rst && rv) begin
            if (expq.size() == 0) begin
                chk("unexpected_rd_valid", 32'(rv), 32'h0);
            end else begin
                chk("rd_data", rdd, expq.pop_front());
            end
        end
    end

    localparam int NOFF = 10;
    logic [11:0] offs[NOFF] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                12'h014, 12'h020, 12'h024, 12'h028, 12'h03C};

    initial begin
        rst = 1'b1; off = 12'h0; wd = 32'h0; we = 1'b0; re = 1'b0;
        cons = 2'd0; st = 6'd0; fd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_arb_weight", 32'(aw), 32'h0000_0FFF);
        chk("rst_wmb", 32'(wmb), 32'h3);
        chk("rst_producer", 32'(prod), 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_rd_valid", 32'(rv), 32'h0);
        chk("rst_rd_data", rdd, 32'h0);

        rd_const(12'h008, 32'h0003_000F);

        // producer range check and rejected-write interrupt
        wr(12'h004, 32'd2);
        chk("prod_eq_2", 32'(prod), 32'd2);
        wr(12'h004, 32'd3);
        chk("prod_kept_2", 32'(prod), 32'd2);
        rd_const(12'h010, 32'h2);
        wr(12'h014, 32'h2);
        tick();
        chk("intr_rej_set", 32'(intr), 32'h1);
        wr(12'h010, 32'h2);
        tick();
        chk("intr_rej_clr", 32'(intr), 32'h0);

        // flush rising edge
        wr(12'h014, 32'h1);
        fd = 1'b1;
        tick();
        tick();
        chk("intr_flush_set", 32'(intr), 32'h1);
        rd_const(12'h010, 32'h1);
        wr(12'h010, 32'h1);
        tick();
        tick();
        rd_const(12'h010, 32'h0);

        // W1C of bit 0 in the same cycle as a flush rise: set wins
        fd = 1'b0;
        tick();
        fd = 1'b1;
        wr(12'h010, 32'h1);
        rd_const(12'h010, 32'h1);
        wr(12'h010, 32'h1);

        // extra channel weights
        wr(12'h024, 32'h5);
        chk("arb_ch2", 32'(aw), 32'h0000_05FF);
        wr(12'h028, 32'hA);
        chk("arb_0x028_ignored", 32'(aw), 32'h0000_05FF);
        rd_const(12'h028, 32'h0);

        // read and write the same offset in one cycle
        re = 1'b1; we = 1'b1; off = 12'h008; wd = 32'h0001_0002;
        force_exp = 1'b1; exp_val = 32'h0003_000F;
        tick();
        force_exp = 1'b0;
        rd_const(12'h008, 32'h0001_0002);
        tick();

        // reset during a pending read, flush_done held high throughout
        re = 1'b1; off = 12'h008;
        #2 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        re = 1'b0;
        #1 rst = 1'b0;
        chk("mid_rst_no_valid", 32'(rv), 32'h0);
        tick();
        tick();
        rd_const(12'h010, 32'h0);
        chk("post_rst_arb", 32'(aw), 32'h0000_0FFF);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            off  = offs[$urandom_range(0, NOFF - 1)];
            we   = 1'($urandom_range(0, 1));
            re   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            if (off == 12'h004 && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) fd = ~fd;
            st   = 6'($urandom);
            cons = 2'($urandom_range(0, 2));
            tick();
        end
        tick();
        tick();
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
